// File: rtl/fetch_pkg.sv
// Shared types and sizes for the instruction fetch front end.
package fetch_pkg;

   localparam int unsigned INSTR_W     = 16;
   localparam int unsigned QUEUE_DEPTH = 2;
   localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH + 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic               valid;
      logic [INSTR_W-1:0] data;
   } queue_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO built as a head/tail shift pair so the head is a plain register.
// Flush beats push; pop together with flush behaves as flush.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [INSTR_W-1:0] push_data,
   input  logic               pop,
   input  logic               flush,
   output logic [INSTR_W-1:0] head_data,
   output logic               head_valid,
   output logic [CNT_W-1:0]   count_c
);

   queue_entry_t head_q;
   queue_entry_t tail_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
      end else if (flush) begin
         // Data is kept so the head word holds its last value while empty
         head_q.valid <= 1'b0;
         tail_q.valid <= 1'b0;
      end else begin
         case ({push, pop && head_q.valid})
            2'b01: begin
               if (tail_q.valid) begin
                  head_q       <= tail_q;
                  tail_q.valid <= 1'b0;
               end else begin
                  head_q.valid <= 1'b0;
               end
            end
            2'b10: begin
               if (!head_q.valid) begin
                  head_q <= '{valid: 1'b1, data: push_data};
               end else if (!tail_q.valid) begin
                  tail_q <= '{valid: 1'b1, data: push_data};
               end
            end
            2'b11: begin
               if (tail_q.valid) begin
                  head_q      <= tail_q;
                  tail_q.data <= push_data;
               end else begin
                  head_q.data <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_data  = head_q.data;
   assign head_valid = head_q.valid;
   assign count_c    = CNT_W'(head_q.valid) + CNT_W'(tail_q.valid);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem reads, 2-entry queue, jump/halt handling.
// Optional FETCH_SKIP_EN adds the skip_enable discard-next-instruction path.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] instruction,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jump_enable,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              halt,
   input  logic              skip_enable,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_d, addr_d;
   logic              req_d, halted_d;
   logic              stale_q, stale_d;
   logic              q_push, q_pop, q_flush;
   logic [CNT_W-1:0]  q_count_c;
   logic              accept, resp;

   assign accept = instr_valid && instr_ready;
   assign resp   = (state_q == WAIT) && imem_rvalid;

`ifdef FETCH_SKIP_EN
   logic skip_q, skip_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) skip_q <= 1'b0;
      else       skip_q <= skip_d;
   end
`else
   logic unused_skip;
   assign unused_skip = skip_enable;
`endif

   fetch_queue u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push),
      .push_data (imem_rdata),
      .pop       (q_pop),
      .flush     (q_flush),
      .head_data (instruction),
      .head_valid(instr_valid),
      .count_c   (q_count_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Next state, queue control and next values of the registered outputs
   always_comb begin
      state_d  = state_q;
      pc_d     = pc;
      addr_d   = imem_addr;
      req_d    = 1'b0;
      stale_d  = stale_q;
      halted_d = halted;
      q_push   = 1'b0;
      q_pop    = accept;
      q_flush  = 1'b0;
`ifdef FETCH_SKIP_EN
      skip_d   = skip_q;
`endif
      if (state_q != HALTED) begin
         if (halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
            q_flush  = 1'b1;
            stale_d  = 1'b0;
`ifdef FETCH_SKIP_EN
            skip_d   = 1'b0;
`endif
         end else if (jump_enable) begin
            pc_d    = jump_target;
            q_flush = 1'b1;
            stale_d = (state_q == WAIT) && !imem_rvalid;
            if (resp) state_d = RUN;
`ifdef FETCH_SKIP_EN
            skip_d  = 1'b0;
`endif
         end else begin
            q_push = resp && !stale_q;
            if (resp) begin
               state_d = RUN;
               stale_d = 1'b0;
            end
`ifdef FETCH_SKIP_EN
            // A pending skip only survives while the queue is empty, so it always targets the next push
            if (skip_enable || skip_q) begin
               skip_d = 1'b0;
               if (instr_valid && !instr_ready)                       q_pop   = 1'b1;
               else if (instr_valid && q_count_c == CNT_W'(QUEUE_DEPTH)) q_flush = 1'b1;
               else if (q_push)                                        q_push  = 1'b0;
               else                                                    skip_d  = 1'b1;
            end
`endif
            // Returning data frees the outstanding slot, so the next read can go out back-to-back
            if ((state_q == RUN || resp) &&
                (q_count_c + CNT_W'(q_push)) < CNT_W'(QUEUE_DEPTH)) begin
               req_d   = 1'b1;
               addr_d  = pc;
               pc_d    = pc + ADDR_W'(1);
               state_d = WAIT;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_req  <= 1'b0;
         imem_addr <= '0;
         pc        <= ADDR_W'(RESET_PC);
         halted    <= 1'b0;
         stale_q   <= 1'b0;
      end else begin
         imem_req  <= req_d;
         imem_addr <= addr_d;
         pc        <= pc_d;
         halted    <= halted_d;
         stale_q   <= stale_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable instruction memory model.
module tb_instr_fetch_unit;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;
   logic [DATA_W-1:0] instruction;
   logic              instr_valid;
   logic              instr_ready;
   logic              jump_enable;
   logic [ADDR_W-1:0] jump_target;
   logic              halt;
   logic              skip_enable;
   logic              halted;
   logic [ADDR_W-1:0] pc;

   int n_checks = 0;
   int n_errors = 0;
   int mem_lat  = 1;
   logic inject = 1'b0;

   bit         mem_pend = 1'b0;
   int         mem_cnt  = 0;
   logic [7:0] mem_a    = '0;
   logic       last_inject = 1'b0;

   instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .instruction(instruction),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .jump_enable(jump_enable),
      .jump_target(jump_target),
      .halt       (halt),
      .skip_enable(skip_enable),
      .halted     (halted),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   // Memory contents: 8801, 9802, A803 ... F808 at 0..7, {5A, addr} elsewhere
   function automatic logic [15:0] word_at(input logic [7:0] a);
      if (a < 8'd8) return {4'(8 + a), 4'h8, 8'(a + 8'd1)};
      return {8'h5A, a};
   endfunction

   // Memory responder: answers mem_lat cycles after a request; a toggle of inject forces a spurious rvalid
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (reset) begin
            mem_pend = 1'b0;
         end else begin
            if (mem_pend) begin
               mem_cnt--;
               if (mem_cnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = word_at(mem_a);
                  mem_pend    = 1'b0;
               end
            end
            if (imem_req) begin
               mem_pend = 1'b1;
               mem_cnt  = mem_lat;
               mem_a    = imem_addr;
            end
            if (inject != last_inject) begin
               imem_rvalid = 1'b1;
               imem_rdata  = 16'hDEAD;
            end
         end
         last_inject = inject;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      instr_ready = 1'b0;
      jump_enable = 1'b0;
      jump_target = '0;
      halt        = 1'b0;
      skip_enable = 1'b0;
      mem_lat     = 1;
      cyc(2);
      chk("rst_req",    32'(imem_req),    32'(0));
      chk("rst_addr",   32'(imem_addr),   32'(0));
      chk("rst_instr",  32'(instruction), 32'(0));
      chk("rst_valid",  32'(instr_valid), 32'(0));
      chk("rst_halted", 32'(halted),      32'(0));
      chk("rst_pc",     32'(pc),          32'(0));
      reset = 1'b0;
   endtask

   // Accept the next presented word (bounded wait) and compare it
   task automatic take(input string name, input logic [15:0] exp);
      bit got = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 30 && !got; i++) begin
         if (instr_valid) begin
            got = 1'b1;
            chk(name, 32'(instruction), 32'(exp));
         end
         @(negedge clk);
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: no instr_valid within 30 cycles, expected %0h", name, exp);
      end
   endtask

   typedef struct {
      logic        ready;
      logic        req;
      logic [7:0]  addr;
      logic        valid;
      logic [15:0] instr;
      logic [7:0]  pc;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int nreq;
      int nvalid;
      int nhalted;
      logic [15:0] skip_exp;

      vecs[0] = '{1'b1, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h01};
      vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h01};
      vecs[2] = '{1'b1, 1'b1, 8'h01, 1'b1, 16'h8801, 8'h02};
      vecs[3] = '{1'b1, 1'b0, 8'h01, 1'b0, 16'h8801, 8'h02};
      vecs[4] = '{1'b1, 1'b1, 8'h02, 1'b1, 16'h9802, 8'h03};
      vecs[5] = '{1'b1, 1'b0, 8'h02, 1'b0, 16'h9802, 8'h03};
      vecs[6] = '{1'b1, 1'b1, 8'h03, 1'b1, 16'hA803, 8'h04};

      // Sequential fetch with 1-cycle memory, always ready: one word every 2 cycles
      do_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk($sformatf("seq%0d_req", i + 1),   32'(imem_req),    32'(vecs[i].req));
         chk($sformatf("seq%0d_addr", i + 1),  32'(imem_addr),   32'(vecs[i].addr));
         chk($sformatf("seq%0d_valid", i + 1), 32'(instr_valid), 32'(vecs[i].valid));
         chk($sformatf("seq%0d_instr", i + 1), 32'(instruction), 32'(vecs[i].instr));
         chk($sformatf("seq%0d_pc", i + 1),    32'(pc),          32'(vecs[i].pc));
         instr_ready = vecs[i].ready;
      end

      // Consumer stalls: queue fills to 2 and requests stop; then drains in order
      do_reset();
      nreq = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (imem_req) nreq++;
      end
      chk("stall_req_count", 32'(nreq),        32'(2));
      chk("stall_valid",     32'(instr_valid), 32'(1));
      chk("stall_head",      32'(instruction), 32'(16'h8801));
      take("stall_take0", 16'h8801);
      take("stall_take1", 16'h9802);
      take("stall_take2", 16'hA803);

      // Reset while a read is outstanding clears outputs immediately
      do_reset();
      mem_lat = 3;
      cyc(1);
      chk("midrd_req_before", 32'(imem_req), 32'(1));
      reset = 1'b1;
      #1;
      chk("midrd_req",  32'(imem_req), 32'(0));
      chk("midrd_pc",   32'(pc),       32'(0));

      // Jump with a read outstanding (3-cycle memory): queue flushed, stale word dropped
      do_reset();
      mem_lat = 3;
      cyc(5);
      chk("jmp_pre_valid", 32'(instr_valid), 32'(1));
      chk("jmp_pre_instr", 32'(instruction), 32'(16'h8801));
      chk("jmp_pre_addr",  32'(imem_addr),   32'(1));
      jump_enable = 1'b1;
      jump_target = 8'h40;
      cyc(1);
      jump_enable = 1'b0;
      chk("jmp_flush_valid", 32'(instr_valid), 32'(0));
      chk("jmp_pc",          32'(pc),          32'(8'h40));
      nreq = 0;
      nvalid = 0;
      for (int i = 0; i < 3; i++) begin
         if (imem_req) nreq++;
         if (instr_valid) nvalid++;
         @(negedge clk);
      end
      chk("jmp_wait_req",   32'(nreq),      32'(0));
      chk("jmp_wait_valid", 32'(nvalid),    32'(0));
      chk("jmp_req",        32'(imem_req),  32'(1));
      chk("jmp_req_addr",   32'(imem_addr), 32'(8'h40));
      chk("jmp_pc_next",    32'(pc),        32'(8'h41));
      take("jmp_take", 16'h5A40);

      // Halt with two words queued: sticky until reset
      do_reset();
      cyc(5);
      chk("halt_pre_valid", 32'(instr_valid), 32'(1));
      halt = 1'b1;
      cyc(1);
      halt = 1'b0;
      instr_ready = 1'b1;
      chk("halt_halted", 32'(halted),      32'(1));
      chk("halt_valid",  32'(instr_valid), 32'(0));
      nreq = 0;
      nvalid = 0;
      nhalted = 0;
      for (int i = 0; i < 20; i++) begin
         jump_enable = (i == 5);
         jump_target = 8'h10;
         @(negedge clk);
         if (imem_req) nreq++;
         if (instr_valid) nvalid++;
         if (halted) nhalted++;
      end
      jump_enable = 1'b0;
      chk("halt_req_count",   32'(nreq),    32'(0));
      chk("halt_valid_count", 32'(nvalid),  32'(0));
      chk("halt_sticky",      32'(nhalted), 32'(20));

      // PC wrap 0xFF -> 0x00, with a spurious rvalid while nothing is outstanding
      do_reset();
      instr_ready = 1'b1;
      jump_enable = 1'b1;
      jump_target = 8'hFF;
      @(posedge clk);
      #1;
      inject = ~inject;
      @(negedge clk);
      jump_enable = 1'b0;
      chk("wrap_pc_ff", 32'(pc),       32'(8'hFF));
      chk("wrap_noreq", 32'(imem_req), 32'(0));
      cyc(1);
      chk("wrap_req_ff",   32'(imem_req),    32'(1));
      chk("wrap_addr_ff",  32'(imem_addr),   32'(8'hFF));
      chk("wrap_pc_00",    32'(pc),          32'(8'h00));
      chk("wrap_spurious", 32'(instr_valid), 32'(0));
      cyc(2);
      chk("wrap_req_00",  32'(imem_req),    32'(1));
      chk("wrap_addr_00", 32'(imem_addr),   32'(8'h00));
      chk("wrap_valid",   32'(instr_valid), 32'(1));
      chk("wrap_instr",   32'(instruction), 32'(16'h5AFF));

      // skip_enable while accepting D806
      do_reset();
      instr_ready = 1'b1;
      jump_enable = 1'b1;
      jump_target = 8'h05;
      cyc(1);
      jump_enable = 1'b0;
      chk("skip_pc", 32'(pc), 32'(8'h05));
      cyc(3);
      chk("skip_head_valid", 32'(instr_valid), 32'(1));
      chk("skip_head",       32'(instruction), 32'(16'hD806));
      skip_enable = 1'b1;
      cyc(1);
      skip_enable = 1'b0;
`ifdef FETCH_SKIP_EN
      skip_exp = 16'hF808;
`else
      skip_exp = 16'hE807;
`endif
      take("skip_next", skip_exp);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
